mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage and upstream of write-back.
- Registers the execute-to-memory bus and accepts the synchronous data-RAM read word.
- Selects the write-back value: ALU result, PC+8, LW word, or sign-extended LB byte.
- Holds RAM read data while write-back stalls, and publishes a bypass bus for ID-stage forwarding.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_stage_load_align.sv | 15 +
 rtl/mem_stage.sv | 79 +++++++
 tb/tb_mem_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared bus widths, write-back source encodings and the execute-to-memory bus layout.
//   EXE_TO_MEM_BUS_WD / MEM_TO_WB_BUS_WD / MEM_TO_BY_BUS_WD : bus widths
//   wd_sel_e       : sel_rf_w_data encodings
//   exe_to_mem_t   : field view of EXE_to_MEM_bus, MSB first
package mem_stage_pkg;
    localparam int EXE_TO_MEM_BUS_WD = 76;
    localparam int MEM_TO_WB_BUS_WD  = 38;
    localparam int MEM_TO_BY_BUS_WD  = 39;
    typedef enum logic [1:0] {
        WD_ALU  = 2'b00,
        WD_PC8  = 2'b01,
        WD_MEM  = 2'b10,
        WD_ZERO = 2'b11
    } wd_sel_e;
    typedef struct packed {
        logic        dm_width;
        wd_sel_e     wd_sel;
        logic        rf_w_en;
        logic        mem_gene;
        logic [1:0]  which_byte;
        logic [31:0] pc_plus_8;
        logic [31:0] exe_data;
        logic [4:0]  w_addr;
    } exe_to_mem_t;
endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align: picks the addressed byte of a load word and sign-extends it for LB; passes the word for LW.
//   load_word  in  32  word read from data RAM (live or held)
//   which_byte in  2   byte lane, 0 = bits [7:0]
//   dm_width   in  1   1 = byte load, 0 = word load
//   result     out 32  value for the register file
module mem_stage_load_align (
    input  logic [31:0] load_word,
    input  logic [1:0]  which_byte,
    input  logic        dm_width,
    output logic [31:0] result
);
    logic [7:0] lane;
    assign lane   = load_word[{which_byte, 3'b000} +: 8];
    assign result = dm_width ? {{24{lane[7]}}, lane} : load_word;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage; registers the execute bus, selects write-back data and publishes a bypass bus.
//   clk, reset        clock and synchronous active-high reset
//   EXE_to_MEM_bus    in  76  instruction bus from execute; EXE_to_MEM_valid qualifies it
//   MEM_allow_in      out 1   stage can take a new instruction this cycle
//   data_ram_r_data   in  32  synchronous RAM read word, valid in the first MEM cycle
//   WB_allow_in       in  1   write-back can accept
//   MEM_to_WB_valid   out 1   MEM_to_WB_bus carries a valid instruction
//   MEM_to_WB_bus     out 38  {w_en, w_data, w_addr}
//   MEM_to_BY_bus     out 39  {w_en, valid, w_addr, w_data} for ID forwarding
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EXE_TO_MEM_BUS_WD = mem_stage_pkg::EXE_TO_MEM_BUS_WD,
    parameter int MEM_TO_WB_BUS_WD  = mem_stage_pkg::MEM_TO_WB_BUS_WD,
    parameter int MEM_TO_BY_BUS_WD  = mem_stage_pkg::MEM_TO_BY_BUS_WD
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
    input  logic                         EXE_to_MEM_valid,
    output logic                         MEM_allow_in,
    input  logic [31:0]                  data_ram_r_data,
    input  logic                         WB_allow_in,
    output logic                         MEM_to_WB_valid,
    output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
    output logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus
);
    exe_to_mem_t r;
    logic        mem_valid;
    logic        mem_ready_go;
    logic        rdata_hold_valid;
    logic [31:0] rdata_hold;
    logic [31:0] load_word;
    logic [31:0] load_result;
    logic [31:0] w_data;
    logic        unused_load_flag;

    assign mem_ready_go     = 1'b1;
    assign MEM_allow_in     = ~mem_valid | (mem_ready_go & WB_allow_in);
    assign MEM_to_WB_valid  = mem_valid & mem_ready_go;
    assign unused_load_flag = r.mem_gene;

    always_ff @(posedge clk) begin
        if (reset)
            mem_valid <= 1'b0;
        else if (MEM_allow_in)
            mem_valid <= EXE_to_MEM_valid;
        if (MEM_allow_in & EXE_to_MEM_valid)
            r <= exe_to_mem_t'(EXE_to_MEM_bus);
    end

    // The RAM is re-addressed by execute every cycle, so the word must be caught on the first stalled cycle.
    always_ff @(posedge clk) begin
        if (reset)
            rdata_hold_valid <= 1'b0;
        else if (MEM_to_WB_valid & WB_allow_in)
            rdata_hold_valid <= 1'b0;
        else if (mem_valid & ~WB_allow_in & ~rdata_hold_valid) begin
            rdata_hold_valid <= 1'b1;
            rdata_hold       <= data_ram_r_data;
        end
    end

    assign load_word = rdata_hold_valid ? rdata_hold : data_ram_r_data;

    mem_stage_load_align u_align (
        .load_word  (load_word),
        .which_byte (r.which_byte),
        .dm_width   (r.dm_width),
        .result     (load_result)
    );

    assign w_data = r.wd_sel == WD_ALU ? r.exe_data :
                    r.wd_sel == WD_PC8 ? r.pc_plus_8 :
                    r.wd_sel == WD_MEM ? load_result : 32'h0;

    assign MEM_to_WB_bus = {r.rf_w_en, w_data, r.w_addr};
    assign MEM_to_BY_bus = {r.rf_w_en, mem_valid, r.w_addr, w_data};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and random checks of mem_stage against a transaction-level reference model.
module tb_mem_stage;
    logic        clk = 0;
    logic        reset;
    logic [75:0] exe_bus;
    logic        exe_valid;
    logic        mem_allow;
    logic [31:0] ram;
    logic        wb_allow;
    logic        wb_valid;
    logic [37:0] wb_bus;
    logic [38:0] by_bus;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: the instruction sitting in MEM and the RAM word it saw on arrival
    bit          m_valid = 0;
    bit          m_first = 0;
    logic [75:0] m_bus;
    logic [31:0] m_word;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .EXE_to_MEM_bus   (exe_bus),
        .EXE_to_MEM_valid (exe_valid),
        .MEM_allow_in     (mem_allow),
        .data_ram_r_data  (ram),
        .WB_allow_in      (wb_allow),
        .MEM_to_WB_valid  (wb_valid),
        .MEM_to_WB_bus    (wb_bus),
        .MEM_to_BY_bus    (by_bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [75:0] mk(input bit dmw, input bit [1:0] sel, input bit wen, input bit ld,
                                       input bit [1:0] lane, input bit [31:0] pc8, input bit [31:0] d,
                                       input bit [4:0] a);
        return {dmw, sel, wen, ld, lane, pc8, d, a};
    endfunction

    function automatic logic [31:0] ref_data(input logic [75:0] b, input logic [31:0] word);
        int v;
        case (b[74:73])
            2'd0: return b[36:5];
            2'd1: return b[68:37];
            2'd2: begin
                if (!b[75]) return word;
                v = int'((word >> (8 * int'(b[70:69]))) & 32'hFF);
                if (v > 127) v -= 256;
                return 32'(v);
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic [75:0] b, input bit v, input bit wa, input logic [31:0] rd, input bit rst);
        @(negedge clk);
        exe_bus = b; exe_valid = v; wb_allow = wa; ram = rd; reset = rst;
        #1;
    endtask

    task automatic model_check();
        logic [31:0] d;
        if (m_valid && m_first) m_word = ram;
        check("allow_in", mem_allow, !m_valid || wb_allow);
        check("wb_valid", wb_valid, m_valid);
        check("by_valid", by_bus[37], m_valid);
        if (m_valid) begin
            d = ref_data(m_bus, m_word);
            check("wb_bus", wb_bus, {m_bus[72], d, m_bus[4:0]});
            check("by_bus", by_bus, {m_bus[72], 1'b1, m_bus[4:0], d});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) m_valid = 0;
        else if (!m_valid || wb_allow) begin
            m_valid = exe_valid;
            if (exe_valid) begin m_bus = exe_bus; m_first = 1; end
        end else m_first = 0;
    endtask

    task automatic cyc(input logic [75:0] b, input bit v, input bit wa, input logic [31:0] rd, input bit rst);
        drive(b, v, wa, rd, rst);
        model_check();
        tick();
    endtask

    initial begin
        logic [31:0] lb_exp [4];
        logic [95:0] rnd;
        logic [75:0] lw;
        lb_exp = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
        lw = mk(0, 2'b10, 1, 1, 0, 0, 0, 5'd9);

        drive('0, 0, 1, 0, 1); tick();
        drive('0, 0, 1, 0, 1); tick();
        drive('0, 0, 1, 0, 0); model_check();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_allow", mem_allow, 1);
        check("rst_by_valid", by_bus[37], 0);
        tick();

        cyc(mk(0, 2'b00, 1, 0, 0, 0, 32'h12345678, 5'd5), 1, 1, 0, 0);
        drive('0, 0, 1, 0, 0); model_check();
        check("alu_wb_bus", wb_bus, {1'b1, 32'h12345678, 5'd5});
        check("alu_wb_valid", wb_valid, 1);
        tick();
        drive('0, 0, 1, 0, 0); model_check();
        check("alu_one_cycle", wb_valid, 0);
        tick();

        cyc(mk(0, 2'b01, 1, 0, 0, 32'hBFC00010, 32'h0, 5'd31), 1, 1, 0, 0);
        drive('0, 0, 1, 0, 0); model_check();
        check("jal_wb_bus", wb_bus, {1'b1, 32'hBFC00010, 5'd31});
        tick();

        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(mk(1, 2'b10, 1, 1, 2'(i), 0, 0, 5'(i + 1)), 1, 1, 32'h80FF7F01, 0);
            else drive('0, 0, 1, 32'h80FF7F01, 0);
            model_check();
            if (i > 0) check("lb_data", wb_bus[36:5], lb_exp[i - 1]);
            tick();
        end

        cyc(lw, 1, 1, 32'h0, 0);
        drive('0, 0, 0, 32'hDEADBEEF, 0); model_check();
        check("lw_stall_data", wb_bus[36:5], 32'hDEADBEEF);
        check("lw_stall_allow", mem_allow, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive('0, 0, 0, 32'h11111111, 0); model_check();
            check("lw_held_data", wb_bus[36:5], 32'hDEADBEEF);
            check("lw_held_allow", mem_allow, 0);
            tick();
        end
        drive(mk(0, 2'b00, 1, 0, 0, 0, 32'h00C0FFEE, 5'd3), 1, 1, 32'h11111111, 0); model_check();
        check("lw_release_data", wb_bus[36:5], 32'hDEADBEEF);
        check("lw_release_valid", wb_valid, 1);
        check("lw_release_allow", mem_allow, 1);
        tick();
        drive(lw, 1, 1, 32'h22222222, 0); model_check();
        check("next_entered", wb_bus, {1'b1, 32'h00C0FFEE, 5'd3});
        tick();
        drive('0, 0, 1, 32'hCAFEF00D, 0); model_check();
        check("hold_cleared", wb_bus[36:5], 32'hCAFEF00D);
        tick();

        cyc(lw, 1, 1, 32'h0, 0);
        cyc('0, 0, 0, 32'hA5A5A5A5, 0);
        cyc('0, 0, 0, 32'h00000001, 1);
        drive(lw, 1, 1, 32'h0, 0); model_check();
        check("rst_stall_valid", wb_valid, 0);
        check("rst_stall_allow", mem_allow, 1);
        tick();
        drive('0, 0, 1, 32'h5A5A5A5A, 0); model_check();
        check("post_rst_lw", wb_bus[36:5], 32'h5A5A5A5A);
        tick();

        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            cyc(rnd[75:0], 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), $urandom(),
                $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
